// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with programmable almost flags, fill count and optional FWFT read mode.
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] rdata_q;
    logic             rd_acc, wr_acc;

    assign rd_acc       = rd_en && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO still takes the write
    assign wr_acc       = wr_en && (!full || rd_acc);
    assign full         = count == CW'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= CW'(AF_THRESH);
    assign almost_empty = count <= CW'(AE_THRESH);
    assign rdata        = (FWFT != 0) ? (empty ? '0 : mem[rd_ptr]) : rdata_q;

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rdata_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(wr_acc);
            rd_ptr    <= rd_ptr + AW'(rd_acc);
            count     <= count + CW'(wr_acc) - CW'(rd_acc);
            rdata_q   <= rd_acc ? mem[rd_ptr] : rdata_q;
            overflow  <= wr_en && !wr_acc;
            underflow <= rd_en && !rd_acc;
        end
    end
endmodule
